// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with OVERSAMPLE clock edges per bit,
// three-sample majority voting, early stop-bit decision and a single-entry
// valid/ready output register with frame-error and overrun reporting.
module uart_receiver #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       CLK_BPS16,
    input  logic       reset,
    input  logic       uart_txd_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_error,
    output logic       overrun,
    output logic       rx_busy,
    output logic [3:0] receive_bit_counter
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MLO  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] TICK_MHI  = TW'(OVERSAMPLE / 2 + 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_HIGH = 3'd4;

    logic          rxs_meta_reg;
    logic          rxs_reg;
    logic [2:0]    state_reg, state_next;
    logic [TW-1:0] tick_reg, tick_next;
    logic [TW-1:0] tick_wrap;
    logic          samp_lo_reg, samp_mid_reg;
    logic          maj_reg;
    logic          maj_now;
    logic [7:0]    shift_reg, shift_next;
    logic [3:0]    bit_cnt_reg, bit_cnt_next;
    logic          complete;
    logic [7:0]    rx_data_reg;
    logic          rx_valid_reg;
    logic          frame_error_reg;
    logic          overrun_reg;

    // Majority of the two stored mid-bit samples and the live third sample.
    assign maj_now   = (samp_lo_reg & samp_mid_reg) | (samp_lo_reg & rxs_reg) | (samp_mid_reg & rxs_reg);
    assign tick_wrap = (tick_reg == TICK_LAST) ? '0 : tick_reg + 1'b1;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge CLK_BPS16 or negedge reset) begin
        if (!reset) begin
            rxs_meta_reg <= 1'b1;
            rxs_reg      <= 1'b1;
        end else begin
            rxs_meta_reg <= uart_txd_in;
            rxs_reg      <= rxs_meta_reg;
        end
    end

    // Next-state logic: bit timing, data shifting and frame completion.
    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt_reg;
        complete     = 1'b0;
        case (state_reg)
            IDLE: begin
                tick_next    = '0;
                bit_cnt_next = 4'd0;
                if (!rxs_reg) state_next = START;
            end
            START: begin
                tick_next    = tick_wrap;
                bit_cnt_next = 4'd0;
                if (tick_reg == TICK_LAST) state_next = maj_reg ? IDLE : DATA;
            end
            DATA: begin
                tick_next = tick_wrap;
                if (tick_reg == TICK_LAST) begin
                    shift_next   = {maj_reg, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 4'd1;
                    if (bit_cnt_reg == 4'd7) state_next = STOP;
                end
            end
            STOP: begin
                tick_next = tick_wrap;
                // Deciding mid-bit leaves half a bit of slack for baud mismatch.
                if (tick_reg == TICK_MHI) begin
                    complete     = 1'b1;
                    bit_cnt_next = 4'd0;
                    state_next   = maj_now ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                tick_next    = '0;
                bit_cnt_next = 4'd0;
                if (rxs_reg) state_next = IDLE;
            end
            default: begin
                state_next   = IDLE;
                tick_next    = '0;
                bit_cnt_next = 4'd0;
            end
        endcase
    end

    // Receiver state registers.
    always_ff @(posedge CLK_BPS16 or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            tick_reg    <= '0;
            shift_reg   <= 8'd0;
            bit_cnt_reg <= 4'd0;
        end else begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            shift_reg   <= shift_next;
            bit_cnt_reg <= bit_cnt_next;
        end
    end

    // Mid-bit samples; the vote is latched at M+1 for use at end of bit.
    always_ff @(posedge CLK_BPS16 or negedge reset) begin
        if (!reset) begin
            samp_lo_reg  <= 1'b1;
            samp_mid_reg <= 1'b1;
            maj_reg      <= 1'b1;
        end else begin
            if (tick_reg == TICK_MLO) samp_lo_reg  <= rxs_reg;
            if (tick_reg == TICK_MID) samp_mid_reg <= rxs_reg;
            if (tick_reg == TICK_MHI) maj_reg      <= maj_now;
        end
    end

    // Output holding register with valid/ready handshake and overrun pulse.
    always_ff @(posedge CLK_BPS16 or negedge reset) begin
        if (!reset) begin
            rx_data_reg     <= 8'd0;
            rx_valid_reg    <= 1'b0;
            frame_error_reg <= 1'b0;
            overrun_reg     <= 1'b0;
        end else begin
            overrun_reg <= 1'b0;
            if (complete) begin
                if (!rx_valid_reg || rx_ready) begin
                    rx_data_reg     <= shift_reg;
                    frame_error_reg <= ~maj_now;
                    rx_valid_reg    <= 1'b1;
                end else begin
                    overrun_reg <= 1'b1;
                end
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data             = rx_data_reg;
    assign rx_valid            = rx_valid_reg;
    assign frame_error         = frame_error_reg;
    assign overrun             = overrun_reg;
    assign rx_busy             = (state_reg != IDLE);
    assign receive_bit_counter = bit_cnt_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames with hand-computed expectations for uart_receiver.
module tb_uart_receiver;

    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       uart_txd_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_error;
    logic       overrun;
    logic       rx_busy;
    logic [3:0] receive_bit_counter;

    int tests = 0;
    int fails = 0;
    int ovr_cnt = 0;

    // Results recorded by drive_frame
    int         valid_edge;
    int         valid_cycles;
    logic [7:0] data_at_valid;
    logic       fe_at_valid;
    logic [3:0] cnt_mid;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic [7:0] exp_data;
        logic       exp_fe;
        int         exp_edge;
    } vec_t;

    vec_t vecs[6];

    uart_receiver #(.OVERSAMPLE(OS)) dut (
        .CLK_BPS16          (clk),
        .reset              (reset),
        .uart_txd_in        (uart_txd_in),
        .rx_data            (rx_data),
        .rx_valid           (rx_valid),
        .rx_ready           (rx_ready),
        .frame_error        (frame_error),
        .overrun            (overrun),
        .rx_busy            (rx_busy),
        .receive_bit_counter(receive_bit_counter)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (overrun) ovr_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, act);
        end
    endtask

    task automatic idle_high(input int n);
        uart_txd_in = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    // Edge 1 is the first edge that sees the start bit on the line.
    task automatic drive_frame(input logic [7:0] d, input logic stop_bit,
                               input int n_edges, input int glitch_edge);
        logic [9:0] bits;
        logic       v;
        int         bi;
        bits          = {stop_bit, d, 1'b0};
        valid_edge    = -1;
        valid_cycles  = 0;
        data_at_valid = 8'hxx;
        fe_at_valid   = 1'bx;
        cnt_mid       = 4'hx;
        for (int e = 1; e <= n_edges; e++) begin
            bi = (e - 1) / OS;
            v  = (bi < 10) ? bits[bi] : stop_bit;
            if (e == glitch_edge) v = ~v;
            uart_txd_in = v;
            step();
            if (rx_valid) begin
                valid_cycles++;
                if (valid_edge < 0) begin
                    valid_edge    = e;
                    data_at_valid = rx_data;
                    fe_at_valid   = frame_error;
                end
            end
            if (e == 150) cnt_mid = receive_bit_counter;
        end
    endtask

    initial begin
        int busy_cnt;
        int first_busy;
        int any_valid;
        int ovr0;

        vecs[0] = '{data: 8'hA5, stop_bit: 1'b1, exp_data: 8'hA5, exp_fe: 1'b0, exp_edge: 157};
        vecs[1] = '{data: 8'hFF, stop_bit: 1'b1, exp_data: 8'hFF, exp_fe: 1'b0, exp_edge: 157};
        vecs[2] = '{data: 8'h00, stop_bit: 1'b1, exp_data: 8'h00, exp_fe: 1'b0, exp_edge: 157};
        vecs[3] = '{data: 8'h80, stop_bit: 1'b1, exp_data: 8'h80, exp_fe: 1'b0, exp_edge: 157};
        vecs[4] = '{data: 8'h01, stop_bit: 1'b1, exp_data: 8'h01, exp_fe: 1'b0, exp_edge: 157};
        vecs[5] = '{data: 8'hC3, stop_bit: 1'b0, exp_data: 8'hC3, exp_fe: 1'b1, exp_edge: 157};

        // Reset state
        reset       = 1'b0;
        uart_txd_in = 1'b1;
        rx_ready    = 1'b1;
        step();
        step();
        check("reset_rx_data", rx_data, 8'h00);
        check("reset_rx_valid", rx_valid, 1'b0);
        check("reset_rx_busy", rx_busy, 1'b0);
        check("reset_bit_counter", receive_bit_counter, 4'd0);
        reset = 1'b1;
        idle_high(4);

        // Table-driven frames with rx_ready held high
        for (int i = 0; i < 6; i++) begin
            drive_frame(vecs[i].data, vecs[i].stop_bit, 10 * OS, 0);
            check($sformatf("v%0d_latency_edge", i), valid_edge, vecs[i].exp_edge);
            check($sformatf("v%0d_rx_data", i), data_at_valid, vecs[i].exp_data);
            check($sformatf("v%0d_frame_error", i), fe_at_valid, vecs[i].exp_fe);
            check($sformatf("v%0d_valid_cycles", i), valid_cycles, 1);
            check($sformatf("v%0d_cnt_in_stop", i), cnt_mid, 4'd8);
            idle_high(4);
            check($sformatf("v%0d_cnt_idle", i), receive_bit_counter, 4'd0);
        end

        // False start: line low 6 clocks
        busy_cnt   = 0;
        first_busy = -1;
        any_valid  = 0;
        for (int e = 1; e <= 30; e++) begin
            uart_txd_in = (e <= 6) ? 1'b0 : 1'b1;
            step();
            if (rx_busy) begin
                busy_cnt++;
                if (first_busy < 0) first_busy = e;
            end
            if (rx_valid) any_valid++;
        end
        check("false_start_busy_cycles", busy_cnt, 16);
        check("false_start_first_busy", first_busy, 3);
        check("false_start_no_valid", any_valid, 0);

        // Stop bit low, line held low 40 more clocks
        drive_frame(8'h3C, 1'b0, 10 * OS + 40, 0);
        check("ferr_rx_data", data_at_valid, 8'h3C);
        check("ferr_frame_error", fe_at_valid, 1'b1);
        check("ferr_single_byte", valid_cycles, 1);
        check("ferr_wait_high_busy", rx_busy, 1'b1);
        check("ferr_data_kept", rx_data, 8'h3C);
        check("ferr_flag_kept", frame_error, 1'b1);
        idle_high(4);
        check("ferr_back_to_idle", rx_busy, 1'b0);

        // Single-clock glitch at tick M of data bit 3 of 0x00
        drive_frame(8'h00, 1'b1, 10 * OS, 74);
        check("glitch_rx_data", data_at_valid, 8'h00);
        check("glitch_frame_error", fe_at_valid, 1'b0);
        idle_high(4);

        // Back-to-back 0x11, 0x22 with consumer stalled
        rx_ready = 1'b0;
        ovr0     = ovr_cnt;
        drive_frame(8'h11, 1'b1, 10 * OS, 0);
        drive_frame(8'h22, 1'b1, 10 * OS, 0);
        idle_high(4);
        check("overrun_pulses", ovr_cnt - ovr0, 1);
        check("overrun_rx_data", rx_data, 8'h11);
        check("overrun_rx_valid", rx_valid, 1'b1);

        // Reset in the middle of data bit 4
        drive_frame(8'h77, 1'b1, 90, 0);
        check("pre_reset_busy", rx_busy, 1'b1);
        check("pre_reset_bit_counter", receive_bit_counter, 4'd4);
        #3;
        reset = 1'b0;
        #1;
        check("midreset_rx_data", rx_data, 8'h00);
        check("midreset_rx_valid", rx_valid, 1'b0);
        check("midreset_frame_error", frame_error, 1'b0);
        check("midreset_overrun", overrun, 1'b0);
        check("midreset_rx_busy", rx_busy, 1'b0);
        check("midreset_bit_counter", receive_bit_counter, 4'd0);
        uart_txd_in = 1'b1;
        step();
        step();
        reset = 1'b1;
        idle_high(20);
        check("post_reset_idle", rx_busy, 1'b0);
        rx_ready = 1'b1;
        drive_frame(8'h5A, 1'b1, 10 * OS, 0);
        check("post_reset_rx_data", data_at_valid, 8'h5A);
        check("post_reset_latency", valid_edge, 157);
        check("post_reset_frame_error", fe_at_valid, 1'b0);
        idle_high(4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 16, meaning clock edges per serial bit; legal values are even integers 8..32.
REQ-002 SHALL have port CLK_BPS16  input  1  meaning oversample clock at OVERSAMPLE x baud; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-004 SHALL have port uart_txd_in  input  1  meaning serial line, idle high, 8N1, LSB first.
REQ-005 SHALL have port rx_data  output  8  meaning the last accepted byte.
REQ-006 SHALL have port rx_valid  output  1  meaning rx_data holds an unconsumed byte.
REQ-007 SHALL have port rx_ready  input  1  meaning the consumer takes rx_data on an edge where rx_valid=1.
REQ-008 SHALL have port frame_error  output  1  meaning the stop bit of the byte in rx_data sampled low.
REQ-009 SHALL have port overrun  output  1  meaning one-cycle pulse when a completed byte is dropped.
REQ-010 SHALL have port rx_busy  output  1  meaning FSM is not in IDLE.
REQ-011 SHALL have port receive_bit_counter  output  4  meaning data bits captured in the current frame, 0..8.

Function
REQ-012 SHALL pass uart_txd_in through a 2-flop synchronizer (rxs); both flops reset to 1.
REQ-013 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 SHALL use tick counter 0..OVERSAMPLE-1: set to 0 on entry to START; increments each edge outside IDLE/WAIT_HIGH; wraps to 0 after OVERSAMPLE-1.
REQ-015 SHALL store rxs at ticks M-1 and M, M=OVERSAMPLE/2; bit value = majority of those two and rxs at tick M+1.
REQ-016 IDLE: rxs=0 -> START; otherwise stay.
REQ-017 START: at tick OVERSAMPLE-1, majority 1 -> IDLE (false start, no output); majority 0 -> DATA with receive_bit_counter=0.
REQ-018 DATA: at tick OVERSAMPLE-1, shift majority into bit 7 of a shift register (LSB first) and increment receive_bit_counter; after the 8th bit -> STOP.
REQ-019 STOP: decision at tick M+1 (not end of bit) to absorb baud mismatch; majority 1 -> IDLE; majority 0 -> WAIT_HIGH; either way the byte is completed on that edge.
REQ-020 WAIT_HIGH: stay until rxs=1, then -> IDLE; no start detection while in WAIT_HIGH.
REQ-021 On completion, if rx_valid=0 or (rx_valid=1 and rx_ready=1): load rx_data and frame_error, set rx_valid=1.
REQ-022 On completion with rx_valid=1 and rx_ready=0: keep rx_data/frame_error, drop new byte, assert overrun for exactly one cycle.
REQ-023 Without completion, rx_valid and rx_ready both 1 at an edge SHALL clear rx_valid on that edge; rx_data and frame_error unchanged.
REQ-024 Frame-errored bytes SHALL still be delivered with frame_error=1.
REQ-025 Latency: counting the first edge at which the synchronizer's first flop captures the start-bit low as edge 1, rx_valid SHALL rise after edge 2+OVERSAMPLE*9+M+2 (edge 156 for OVERSAMPLE=16).
REQ-026 receive_bit_counter SHALL be 0 in IDLE/START and return to 0 on exit from STOP.

Reset
REQ-027 reset=0 SHALL immediately force FSM to IDLE, tick and shift register to 0, synchronizer flops to 1.
REQ-028 reset=0 SHALL immediately force rx_data=0, rx_valid=0, frame_error=0, overrun=0, rx_busy=0, receive_bit_counter=0, including mid-frame.
REQ-029 After release, first start detection SHALL need rxs=0 from the freshly reset synchronizer (no stale frame resumes).

Verification
REQ-030 0xA5 frame, 16 clocks/bit, rx_ready=1 -> rx_data=0xA5, frame_error=0, rx_valid high one cycle after edge 156.
REQ-031 Line low 6 clocks then high -> no rx_valid; rx_busy high 16 clocks then low.
REQ-032 0x3C with stop bit low, line held low 40 more clocks -> rx_data=0x3C, frame_error=1; no new start until line high.
REQ-033 0x11 then 0x22 back-to-back, rx_ready=0 -> rx_data stays 0x11, overrun pulses once at second completion.
REQ-034 Single-clock glitch at tick M of data bit 3 of 0x00 -> rx_data=0x00 (majority rejects).
REQ-035 reset low during data bit 4 -> all outputs 0 at once; after release 0x5A received correctly.
